hr_local_ni: RTL and testbench

// - Core-side network interface for one local port pair of an HRnode ring stop.
// - Injection: buffers core flits and drives them onto HRnode port*_local_i.

---
 rtl/hr_local_ni_pkg.sv | 14 +
 rtl/hr_flit_fifo.sv | 53 +++++
 rtl/hr_local_ni.sv | 86 ++++++++
 tb/tb_hr_local_ni.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hr_local_ni_pkg.sv
// rtl/hr_local_ni_pkg.sv - shared flit widths, types and helpers for the HRnode local NI
package hr_local_ni_pkg;

  localparam int FLIT_W     = 144;
  localparam int FLIT_VALID = 0;
  localparam int STARVE_W   = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic logic flit_is_valid(input flit_t f);
    return f[FLIT_VALID];
  endfunction

endpackage

// File: rtl/hr_flit_fifo.sv
// rtl/hr_flit_fifo.sv - registered flit FIFO with same-cycle push/pop
module hr_flit_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hr_local_ni.sv
// rtl/hr_local_ni.sv - core-side network interface for one HRnode local port pair
module hr_local_ni
  import hr_local_ni_pkg::*;
#(
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 4,
  parameter int STARVE_LIM = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inj_valid,
  input  logic [FLIT_W-1:0] inj_flit,
  output logic              inj_ready,
  output logic [FLIT_W-1:0] node_local_i,
  input  logic              node_ack,
  input  logic [FLIT_W-1:0] node_local_o,
  output logic              ej_valid,
  output logic [FLIT_W-1:0] ej_flit,
  input  logic              ej_ready,
  output logic              starve,
  output logic              ej_overflow,
  output logic              ack_err
);

  logic                inj_full;
  logic                inj_empty;
  logic                inj_push;
  logic                inj_pop;
  logic [FLIT_W-1:0]   inj_head;
  logic                ej_full;
  logic                ej_empty;
  logic                ej_push;
  logic                ej_pop;
  logic [STARVE_W-1:0] starve_cnt;

  // Ready is deliberately independent of node_ack: no bypass through a full FIFO.
  assign inj_ready    = ~inj_full;
  assign inj_push     = inj_valid & inj_ready;
  assign inj_pop      = node_ack & ~inj_empty;
  assign node_local_i = inj_empty ? '0 : inj_head;

  assign ej_push  = flit_is_valid(node_local_o);
  assign ej_pop   = ej_ready & ~ej_empty;
  assign ej_valid = ~ej_empty;

  assign starve = (starve_cnt == STARVE_W'(STARVE_LIM));

  hr_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inj_push),
    .pop   (inj_pop),
    .din   (inj_flit),
    .dout  (inj_head),
    .full  (inj_full),
    .empty (inj_empty)
  );

  hr_flit_fifo #(.WIDTH(FLIT_W), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ej_push),
    .pop   (ej_pop),
    .din   (node_local_o),
    .dout  (ej_flit),
    .full  (ej_full),
    .empty (ej_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt  <= '0;
      ej_overflow <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      if (inj_pop || inj_empty)
        starve_cnt <= '0;
      else if (!starve)
        starve_cnt <= starve_cnt + STARVE_W'(1);
      // The ring cannot be stalled, so an ejected flit with nowhere to go is lost.
      if (ej_push && ej_full && !ej_pop) ej_overflow <= 1'b1;
      if (node_ack && inj_empty)         ack_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hr_local_ni.sv
// tb/tb_hr_local_ni.sv - directed self-checking bench for hr_local_ni
module tb_hr_local_ni;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inj_valid = 1'b0;
  logic [143:0] inj_flit = '0;
  logic         inj_ready;
  logic [143:0] node_local_i;
  logic         node_ack = 1'b0;
  logic [143:0] node_local_o = '0;
  logic         ej_valid;
  logic [143:0] ej_flit;
  logic         ej_ready = 1'b0;
  logic         starve;
  logic         ej_overflow;
  logic         ack_err;

  int n_cmp = 0;
  int n_bad = 0;

  hr_local_ni #(.INJ_DEPTH(4), .EJ_DEPTH(4), .STARVE_LIM(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .inj_valid    (inj_valid),
    .inj_flit     (inj_flit),
    .inj_ready    (inj_ready),
    .node_local_i (node_local_i),
    .node_ack     (node_ack),
    .node_local_o (node_local_o),
    .ej_valid     (ej_valid),
    .ej_flit      (ej_flit),
    .ej_ready     (ej_ready),
    .starve       (starve),
    .ej_overflow  (ej_overflow),
    .ack_err      (ack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] mk_inj(input int i);
    return {16'hA500 + 16'(i), 112'h0, 16'h1851 + 16'(i * 16)};
  endfunction

  function automatic logic [143:0] mk_ej(input int i);
    return {16'h5A00 + 16'(i), 112'h0, 16'h1853 + 16'(i * 16)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inj_valid    = 1'b0;
    inj_flit     = '0;
    node_ack     = 1'b0;
    node_local_o = '0;
    ej_ready     = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (node_local_i !== '0) begin n_bad++; $display("FAIL reset_node_local_i: got %h exp 0", node_local_i); end
    n_cmp++; if (ej_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ej_valid: got %b exp 0", ej_valid); end
    n_cmp++; if (inj_ready !== 1'b1) begin n_bad++; $display("FAIL reset_inj_ready: got %b exp 1", inj_ready); end
    n_cmp++; if ({starve, ej_overflow, ack_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b exp 000", {starve, ej_overflow, ack_err}); end
    inj_valid    = 1'b1;
    inj_flit     = mk_inj(0);
    node_local_o = mk_ej(0);
    tick();
    inj_valid    = 1'b0;
    node_local_o = '0;
    n_cmp++; if (node_local_i !== mk_inj(0) || ej_valid !== 1'b1) begin n_bad++; $display("FAIL pre_async_state: got %h/%b exp %h/1", node_local_i, ej_valid, mk_inj(0)); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (node_local_i !== '0 || ej_valid !== 1'b0 || inj_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset: got %h/%b/%b exp 0/0/1", node_local_i, ej_valid, inj_ready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_inject();
    do_reset();
    inj_valid = 1'b1;
    inj_flit  = mk_inj(0);
    tick();
    inj_valid = 1'b0;
    n_cmp++; if (node_local_i !== mk_inj(0)) begin n_bad++; $display("FAIL single_visible: got %h exp %h", node_local_i, mk_inj(0)); end
    node_ack = 1'b1;
    tick();
    node_ack = 1'b0;
    n_cmp++; if (node_local_i !== '0) begin n_bad++; $display("FAIL single_popped: got %h exp 0", node_local_i); end
    n_cmp++; if (inj_ready !== 1'b1 || ack_err !== 1'b0) begin n_bad++; $display("FAIL single_ready_err: got %b/%b exp 1/0", inj_ready, ack_err); end
  endtask

  task automatic test_full_starve();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1;
      inj_flit  = mk_inj(i);
      tick();
    end
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b exp 0", inj_ready); end
    n_cmp++; if (node_local_i !== mk_inj(0)) begin n_bad++; $display("FAIL full_head: got %h exp %h", node_local_i, mk_inj(0)); end
    inj_flit = mk_inj(9);
    tick();
    inj_valid = 1'b0;
    repeat (10) tick();
    n_cmp++; if (starve !== 1'b0) begin n_bad++; $display("FAIL starve_early: got %b exp 0", starve); end
    tick();
    n_cmp++; if (starve !== 1'b1) begin n_bad++; $display("FAIL starve_set: got %b exp 1", starve); end
    node_ack = 1'b1;
    tick();
    node_ack = 1'b0;
    n_cmp++; if (starve !== 1'b0 || inj_ready !== 1'b1) begin n_bad++; $display("FAIL starve_clear: got %b/%b exp 0/1", starve, inj_ready); end
    n_cmp++; if (node_local_i !== mk_inj(1)) begin n_bad++; $display("FAIL head_advance: got %h exp %h", node_local_i, mk_inj(1)); end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [143:0] exp_q [3];
    inj_valid = 1'b1;
    inj_flit  = mk_inj(4);
    tick();
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL refill_ready: got %b exp 0", inj_ready); end
    inj_flit = mk_inj(5);
    node_ack = 1'b1;
    #1;
    n_cmp++; if (inj_ready !== 1'b0) begin n_bad++; $display("FAIL full_ack_ready: got %b exp 0", inj_ready); end
    tick();
    n_cmp++; if (node_local_i !== mk_inj(2) || inj_ready !== 1'b1) begin n_bad++; $display("FAIL full_ack_pop: got %h/%b exp %h/1", node_local_i, inj_ready, mk_inj(2)); end
    tick();
    inj_valid = 1'b0;
    node_ack  = 1'b0;
    n_cmp++; if (node_local_i !== mk_inj(3) || inj_ready !== 1'b1) begin n_bad++; $display("FAIL push_pop_count: got %h/%b exp %h/1", node_local_i, inj_ready, mk_inj(3)); end
    exp_q[0] = mk_inj(3);
    exp_q[1] = mk_inj(4);
    exp_q[2] = mk_inj(5);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (node_local_i !== exp_q[i]) begin n_bad++; $display("FAIL inj_order[%0d]: got %h exp %h", i, node_local_i, exp_q[i]); end
      node_ack = 1'b1;
      tick();
      node_ack = 1'b0;
    end
    n_cmp++; if (node_local_i !== '0 || ack_err !== 1'b0) begin n_bad++; $display("FAIL inj_drained: got %h/%b exp 0/0", node_local_i, ack_err); end
  endtask

  task automatic test_eject_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      node_local_o = mk_ej(i);
      tick();
      if (i == 0) begin
        n_cmp++; if (ej_valid !== 1'b1 || ej_flit !== mk_ej(0)) begin n_bad++; $display("FAIL ej_first: got %b/%h exp 1/%h", ej_valid, ej_flit, mk_ej(0)); end
      end
      if (i == 3) begin
        n_cmp++; if (ej_overflow !== 1'b0) begin n_bad++; $display("FAIL ej_no_ovf_yet: got %b exp 0", ej_overflow); end
      end
    end
    node_local_o = '0;
    n_cmp++; if (ej_overflow !== 1'b1) begin n_bad++; $display("FAIL ej_overflow: got %b exp 1", ej_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (ej_valid !== 1'b1 || ej_flit !== mk_ej(i)) begin n_bad++; $display("FAIL ej_order[%0d]: got %b/%h exp 1/%h", i, ej_valid, ej_flit, mk_ej(i)); end
      ej_ready = 1'b1;
      tick();
      ej_ready = 1'b0;
    end
    n_cmp++; if (ej_valid !== 1'b0 || ej_overflow !== 1'b1) begin n_bad++; $display("FAIL ej_drained: got %b/%b exp 0/1", ej_valid, ej_overflow); end
  endtask

  task automatic test_eject_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      node_local_o = mk_ej(i);
      tick();
    end
    node_local_o = mk_ej(4);
    ej_ready     = 1'b1;
    tick();
    ej_ready     = 1'b0;
    node_local_o = '0;
    n_cmp++; if (ej_overflow !== 1'b0) begin n_bad++; $display("FAIL ej_full_pop_ovf: got %b exp 0", ej_overflow); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++; if (ej_valid !== 1'b1 || ej_flit !== mk_ej(i)) begin n_bad++; $display("FAIL ej_full_pop_order[%0d]: got %b/%h exp 1/%h", i, ej_valid, ej_flit, mk_ej(i)); end
      ej_ready = 1'b1;
      tick();
      ej_ready = 1'b0;
    end
    n_cmp++; if (ej_valid !== 1'b0) begin n_bad++; $display("FAIL ej_full_pop_empty: got %b exp 0", ej_valid); end
  endtask

  task automatic test_ack_err();
    do_reset();
    node_ack = 1'b1;
    tick();
    node_ack = 1'b0;
    n_cmp++; if (ack_err !== 1'b1 || node_local_i !== '0 || inj_ready !== 1'b1) begin n_bad++; $display("FAIL ack_err_set: got %b/%h/%b exp 1/0/1", ack_err, node_local_i, inj_ready); end
    inj_valid = 1'b1;
    inj_flit  = mk_inj(7);
    tick();
    inj_valid = 1'b0;
    n_cmp++; if (ack_err !== 1'b1 || node_local_i !== mk_inj(7)) begin n_bad++; $display("FAIL ack_err_sticky: got %b/%h exp 1/%h", ack_err, node_local_i, mk_inj(7)); end
    do_reset();
    n_cmp++; if (ack_err !== 1'b0) begin n_bad++; $display("FAIL ack_err_reset: got %b exp 0", ack_err); end
  endtask

  initial begin
    test_reset();
    test_single_inject();
    test_full_starve();
    test_push_pop_same_cycle();
    test_eject_overflow();
    test_eject_full_pop();
    test_ack_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
